// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
//   Receive end of the XOR-parity serial link. A frame on the line is
//     start(0) | DATA_W data bits, LSB first | parity bit | stop(1)
//   Only bits qualified by bit_valid are consumed. Parity is tracked with a
//   running XOR across the data bits and the parity bit. A good stop bit
//   publishes the word with a one-cycle data_valid pulse. parity_err is
//   raised alongside data_valid when the XOR does not match PARITY_ODD. A bad
//   stop bit raises frame_err alone and leaves data_out untouched.
//
// Parameters
//   DATA_W      data bits per frame (1..16)
//   PARITY_ODD  0: XOR(data, parity) must be 0; 1: it must be 1
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   bit_valid   serial_in carries a bit to accept this cycle
//   serial_in   serial line, idles high
//   data_out    last correctly framed word, held between frames
//   data_valid  one-cycle pulse, data_out updated
//   parity_err  one-cycle pulse with data_valid on parity mismatch
//   frame_err   one-cycle pulse when the stop bit was 0
//   busy        frame in progress
// -----------------------------------------------------------------------------
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  // The counter only has to reach DATA_W-1; the last data bit is detected by
  // comparison, not by overflow.
  localparam int CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q,   par_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic              dv_q,    dv_d;
  logic              pe_q,    pe_d;
  logic              fe_q,    fe_d;

  // New bit enters at the MSB and everything moves toward bit 0, so after
  // DATA_W shifts the first (LSB-first) bit sits in bit 0. Written as a loop
  // so DATA_W=1 needs no special-cased slice.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                 input logic              b);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W - 1; i++) begin
      r[i] = cur[i+1];
    end
    r[DATA_W-1] = b;
    return r;
  endfunction

  function automatic logic parity_fail(input logic acc);
    return acc != PARITY_ODD;
  endfunction

  // Next-state and output decode. Nothing advances without bit_valid, and the
  // pulse flags default low so they last exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          shift_d = shift_in(shift_q, serial_in);
          par_d   = par_q ^ serial_in;
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_d   = par_q ^ serial_in;
          state_d = STOP;
        end
        STOP: begin
          // A zero stop bit returns to IDLE but is not taken as a start bit.
          state_d = IDLE;
          if (serial_in) begin
            dout_d = shift_q;
            dv_d   = 1'b1;
            pe_d   = parity_fail(par_q);
          end else begin
            fe_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_valid;
  logic       serial_in;

  logic [7:0] dout0, dout1;
  logic       dv0, pe0, fe0, busy0;
  logic       dv1, pe1, fe1, busy1;

  int vectors = 0;
  int miscompares = 0;
  int dv_cnt = 0;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .serial_in(serial_in),
    .data_out(dout0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0), .busy(busy0)
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .serial_in(serial_in),
    .data_out(dout1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1), .busy(busy1)
  );

  // Pulse counter for the even-parity receiver, sampled mid-cycle.
  always @(negedge clk) if (dv0 === 1'b1) dv_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b0;
    serial_in = 1'b1;
    for (int g = 0; g < gap; g++) tick();
    bit_valid = 1'b1;
    serial_in = b;
    tick();
  endtask

  // Sends a whole frame; returns just after the edge that accepted the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp, input int gap);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    send_bit(stp, gap);
  endtask

  task automatic go_idle();
    bit_valid = 1'b0;
    serial_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bit_valid = 1'b0; serial_in = 1'b1;
    tick(); tick();
    vectors++;
    if ({dout0, dv0, pe0, fe0, busy0} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_even: got %h required 000", {dout0, dv0, pe0, fe0, busy0});
    end
    vectors++;
    if ({dout1, dv1, pe1, fe1, busy1} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_odd: got %h required 000", {dout1, dv1, pe1, fe1, busy1});
    end
    rst_n = 1'b1;
    bit_valid = 1'b1; serial_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if ({dout0, dv0, pe0, fe0, busy0, dout1, dv1, pe1, fe1, busy1} !== 24'h000000) begin
        miscompares++;
        $display("FAIL idle_line cycle %0d: got %h required 000000", c,
                 {dout0, dv0, pe0, fe0, busy0, dout1, dv1, pe1, fe1, busy1});
      end
    end
  endtask

  task automatic test_good_frame();
    send_bit(1'b0, 0);
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b required 1", busy0);
    end
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    vectors++;
    if (busy0 !== 1'b1 || dv0 !== 1'b0) begin
      miscompares++;
      $display("FAIL before_stop: busy=%b dv=%b required busy=1 dv=0", busy0, dv0);
    end
    send_bit(1'b1, 0);
    vectors++;
    if ({dout0, dv0, pe0, fe0, busy0} !== {8'hA5, 4'b1000}) begin
      miscompares++;
      $display("FAIL good_a5: got data=%h dv=%b pe=%b fe=%b busy=%b required a5 1 0 0 0",
               dout0, dv0, pe0, fe0, busy0);
    end
    go_idle();
    vectors++;
    if ({dout0, dv0, pe0, fe0, busy0} !== {8'hA5, 4'b0000}) begin
      miscompares++;
      $display("FAIL good_a5_pulse_end: got data=%h dv=%b pe=%b fe=%b busy=%b required a5 0 0 0 0",
               dout0, dv0, pe0, fe0, busy0);
    end
  endtask

  task automatic test_parity_error();
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    vectors++;
    if ({dout0, dv0, pe0, fe0} !== {8'hA5, 3'b110}) begin
      miscompares++;
      $display("FAIL parity_err_even: got data=%h dv=%b pe=%b fe=%b required a5 1 1 0",
               dout0, dv0, pe0, fe0);
    end
    vectors++;
    if ({dout1, dv1, pe1, fe1} !== {8'hA5, 3'b100}) begin
      miscompares++;
      $display("FAIL parity_ok_odd: got data=%h dv=%b pe=%b fe=%b required a5 1 0 0",
               dout1, dv1, pe1, fe1);
    end
    go_idle();
    vectors++;
    if (pe0 !== 1'b0 || dv0 !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_err_pulse_end: pe=%b dv=%b required 0 0", pe0, dv0);
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    vectors++;
    if ({dout0, dv0, pe0, fe0, busy0} !== {8'hA5, 4'b0010}) begin
      miscompares++;
      $display("FAIL frame_err: got data=%h dv=%b pe=%b fe=%b busy=%b required a5 0 0 1 0",
               dout0, dv0, pe0, fe0, busy0);
    end
    // Zero stop bit must not count as a start bit; line now idles high.
    bit_valid = 1'b1; serial_in = 1'b1;
    tick();
    vectors++;
    if (fe0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_err_after: fe=%b busy=%b required 0 0", fe0, busy0);
    end
  endtask

  task automatic test_back_to_back();
    dv_cnt = 0;
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    vectors++;
    if ({dout0, dv0, pe0, fe0} !== {8'h5A, 3'b100}) begin
      miscompares++;
      $display("FAIL gapped_5a: got data=%h dv=%b pe=%b fe=%b required 5a 1 0 0",
               dout0, dv0, pe0, fe0);
    end
    send_bit(1'b0, 0);
    vectors++;
    if (dv_cnt !== 1 || busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL gapped_single_pulse: pulses=%0d busy=%b required 1 1", dv_cnt, busy0);
    end
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    vectors++;
    if ({dout0, dv0, pe0, fe0} !== {8'hFF, 3'b100}) begin
      miscompares++;
      $display("FAIL b2b_ff: got data=%h dv=%b pe=%b fe=%b required ff 1 0 0",
               dout0, dv0, pe0, fe0);
    end
    go_idle();
    go_idle();
    vectors++;
    if (dv_cnt !== 2) begin
      miscompares++;
      $display("FAIL b2b_pulse_count: got %0d required 2", dv_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    rst_n = 1'b0; bit_valid = 1'b1; serial_in = 1'b1;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({dout0, dv0, pe0, fe0, busy0} !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset: got %h required 000", {dout0, dv0, pe0, fe0, busy0});
    end
    go_idle();
    vectors++;
    if ({dv0, pe0, fe0, busy0} !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_quiet: got %b required 0000", {dv0, pe0, fe0, busy0});
    end
    send_frame(8'h01, 1'b1, 1'b1, 0);
    vectors++;
    if ({dout0, dv0, pe0, fe0} !== {8'h01, 3'b100}) begin
      miscompares++;
      $display("FAIL after_reset_01: got data=%h dv=%b pe=%b fe=%b required 01 1 0 0",
               dout0, dv0, pe0, fe0);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Serial frame receiver with parity check; the receive end of the team's XOR-based parity generator / serial transmitter path.
- Shifts in a start bit, DATA_W data bits LSB first, one parity bit and one stop bit.
- Checks parity with a running XOR and frames the stop bit.
- Presents the received word with a one-cycle valid pulse and error flags.

Parameters:
- DATA_W, 8, number of data bits per frame (legal 1..16).
- PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset (sampled on the clk rising edge).
- bit_valid  input  1  serial_in holds a bit to accept this cycle; bits with bit_valid=0 are ignored.
- serial_in  input  1  serial line; idle level 1.
- data_out  output  DATA_W  last received word; held between frames.
- data_valid  output  1  one-cycle pulse: data_out was updated this cycle.
- parity_err  output  1  one-cycle pulse with data_valid when the parity check failed.
- frame_err  output  1  one-cycle pulse when the stop bit was 0.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, bit counter=0, shift register=0, running parity=0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Reset overrides any frame in progress; the partial frame is discarded with no flags.
- All outputs are registered. data_valid, parity_err and frame_err are high for exactly one cycle. They never coincide with a frame_err pulse from the same frame.
- FSM states: IDLE, DATA, PARITY, STOP. Every transition requires bit_valid=1; with bit_valid=0 the state, counter and accumulators hold.
  - IDLE: serial_in=0 -> DATA; clear counter, shift register and running parity. serial_in=1 -> stay in IDLE (line idle).
  - DATA: shift serial_in into the shift register MSB side, so the first data bit ends in bit 0. Running parity ^= serial_in. Increment the counter. After the DATA_W-th bit -> PARITY.
  - PARITY: running parity ^= serial_in -> STOP.
  - STOP, serial_in=1 -> IDLE:
    - next cycle: data_out=shift register, data_valid=1.
    - parity_err=1 iff final running parity != PARITY_ODD.
  - STOP, serial_in=0 -> IDLE:
    - next cycle: frame_err=1, data_valid=0, parity_err=0.
    - data_out unchanged.
- Latency: flags and data_out update in the cycle immediately after the clock edge that accepts the stop bit.
- Back-to-back frames: a start bit accepted in the cycle right after the stop bit is legal. The FSM is already in IDLE, so no idle bit is required.
- A stop bit of 0 does not start a new frame. The receiver returns to IDLE and waits for the next accepted 0.
- busy goes high the cycle after the start bit is accepted. It goes low the cycle after the stop bit is accepted.
- The counter is wide enough for DATA_W; no wrap occurs inside a frame.

Test Plan (DATA_W=8, PARITY_ODD=0 unless noted; frames listed as accepted bits):
- Reset then idle line (serial_in=1, bit_valid=1 for 20 cycles) -> all outputs 0, busy=0 throughout.
- Good frame 0xA5: bits 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1 -> one cycle after the stop bit: data_out=8'hA5, data_valid=1, parity_err=0, frame_err=0; busy=0 afterwards.
- Parity error: same frame with parity bit 1 -> data_out=8'hA5, data_valid=1, parity_err=1. Repeat with PARITY_ODD=1 and parity 1 -> parity_err=0.
- Framing error: 0x3C frame with stop bit 0 -> frame_err=1, data_valid=0, data_out keeps the previous value 8'hA5.
- Gaps and back-to-back:
  - send 0x5A with bit_valid=0 for 3 cycles between every bit -> data_out=8'h5A, data_valid pulse exactly once.
  - then send 0xFF immediately after the stop bit -> second pulse with data_out=8'hFF, parity_err=0.
- Reset mid-frame: rst_n=0 for one cycle after 4 data bits -> busy=0, no flags. A following complete 0x01 frame (parity 1) -> data_out=8'h01, data_valid=1, parity_err=0.
